// File: rtl/imem_boot_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_boot_loader_pkg
//   Shared types and constants for the serial instruction-memory boot loader.
//   - loader_state_t         : frame-parsing FSM states
//   - SYNC_BYTE_DEFAULT      : default frame start marker
//   - TIMEOUT_CYCLES_DEFAULT : default inter-byte timeout (LOADER_TIMEOUT_EN builds)
//   - TIMEOUT_W              : width of a counter able to hold TIMEOUT_CYCLES_DEFAULT
// ----------------------------------------------------------------------------
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT      = 8'hA5;
  localparam int         TIMEOUT_CYCLES_DEFAULT = 100000;
  localparam int         TIMEOUT_W              = $clog2(TIMEOUT_CYCLES_DEFAULT + 1);

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// ----------------------------------------------------------------------------
// loader_word_packer
//   Packs four consecutive bytes into a 32-bit little-endian word.
//   Byte k of a word (k = 0..3) lands in bits [8*k+7:8*k].
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-high reset
//   clear       in   1   restart packing at byte 0 (new frame)
//   byte_en     in   1   byte_in is consumed this cycle
//   byte_in     in   8   data byte
//   word_full   out  1   this cycle consumes the 4th byte of a word
//   packed_word out  32  word including the byte being consumed this cycle
// ----------------------------------------------------------------------------
module loader_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] packed_word
);

  logic [1:0]  byte_idx;
  logic [31:0] pack_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= 2'd0;
      pack_q   <= 32'd0;
    end else if (clear) begin
      byte_idx <= 2'd0;
      pack_q   <= 32'd0;
    end else if (byte_en) begin
      pack_q[{byte_idx, 3'b000} +: 8] <= byte_in;
      byte_idx                        <= byte_idx + 2'd1;
    end
  end

  // Merge the incoming byte combinationally so the owner can register the
  // complete word on the same edge that consumes the 4th byte.
  always_comb begin
    packed_word                          = pack_q;
    packed_word[{byte_idx, 3'b000} +: 8] = byte_in;
    word_full                            = byte_en && (byte_idx == 2'd3);
  end

endmodule

// File: rtl/imem_boot_loader.sv
// ----------------------------------------------------------------------------
// imem_boot_loader
//   Serial boot loader that fills the core's instruction memory from a UART
//   byte stream.  Frame: SYNC, LEN, 4*LEN data bytes (little-endian words),
//   XOR checksum of the data bytes.  The core is held in reset until a good
//   frame has been completely written.
//
// Configuration macro: LOADER_TIMEOUT_EN
//   defined   : an inter-byte timeout counter sends LEN/DATA/CHK to ERR after
//               TIMEOUT_CYCLES cycles with no accepted byte (SYNC never times out)
//   undefined : no counter; the loader waits indefinitely in any state
//
// Handshake: a byte is transferred on a rising edge where rx_valid && rx_ready.
//   rx_ready is high only in SYNC/LEN/DATA/CHK; the sender may hold rx_valid
//   high and bytes are then accepted every cycle.
//
// Ports
//   clk          in   1       system clock, rising edge
//   reset        in   1       asynchronous, active-high reset
//   start        in   1       arm loader (single-cycle pulse; IDLE/DONE/ERR only)
//   rx_data      in   8       received byte
//   rx_valid     in   1       rx_data valid
//   rx_ready     out  1       loader can accept a byte
//   imem_we      out  1       instruction-memory write strobe (one cycle per word)
//   imem_addr    out  ADDR_W  word-aligned byte address
//   imem_wdata   out  32      word to write
//   core_hold    out  1       core reset; 1 = core held
//   done         out  1       good image loaded (level)
//   error        out  1       frame rejected (level)
//   words_loaded out  7       words written in the current frame
//
// The FSM state is observable as the internal signal `state`.
// ----------------------------------------------------------------------------
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int         ADDR_W         = 8,
  parameter int         DEPTH_WORDS    = 64,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [6:0]        words_loaded
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH_WORDS);

  loader_state_t state;
  logic [7:0]    checksum;
  logic [6:0]    len_q;
  logic          accept;
  logic          in_frame;
  logic          restart;
  logic          timeout_hit;
  logic          word_full;
  logic [31:0]   packed_word;

  // rx_ready decodes the state register only, so it is glitch-free and
  // changes exactly on the edge that moves the FSM.
  assign rx_ready = (state == SYNC) || (state == LEN) || (state == DATA) || (state == CHK);
  assign accept   = rx_valid && rx_ready;
  assign in_frame = (state == LEN) || (state == DATA) || (state == CHK);
  assign restart  = start && ((state == IDLE) || (state == DONE) || (state == ERR));

  loader_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (restart),
    .byte_en     (accept && (state == DATA)),
    .byte_in     (rx_data),
    .word_full   (word_full),
    .packed_word (packed_word)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  // Counts idle cycles inside a frame.  Outside LEN/DATA/CHK it sits at zero,
  // which also gives the required clear on entry to LEN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (accept || !in_frame) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive idle edge.
  assign timeout_hit = in_frame && !accept && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      words_loaded <= 7'd0;
      checksum     <= 8'd0;
      len_q        <= 7'd0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= SYNC;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 7'd0;
            checksum     <= 8'd0;
            len_q        <= 7'd0;
          end
        end

        SYNC: begin
          // Anything other than the marker is line noise and is dropped.
          if (accept && (rx_data == SYNC_BYTE)) begin
            state <= LEN;
          end
        end

        LEN: begin
          if (accept) begin
            if (rx_data > DEPTH_B) begin
              state <= ERR;
              error <= 1'b1;
            end else if (rx_data == 8'd0) begin
              state <= CHK;
            end else begin
              state <= DATA;
              len_q <= rx_data[6:0];
            end
          end else if (timeout_hit) begin
            state <= ERR;
            error <= 1'b1;
          end
        end

        DATA: begin
          if (accept) begin
            checksum <= checksum ^ rx_data;
            if (word_full) begin
              imem_we      <= 1'b1;
              imem_addr    <= ADDR_W'({words_loaded, 2'b00});
              imem_wdata   <= packed_word;
              words_loaded <= words_loaded + 7'd1;
              if ((words_loaded + 7'd1) == len_q) begin
                state <= CHK;
              end
            end
          end else if (timeout_hit) begin
            state <= ERR;
            error <= 1'b1;
          end
        end

        CHK: begin
          if (accept) begin
            if (rx_data == checksum) begin
              state     <= DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end else if (timeout_hit) begin
            state <= ERR;
            error <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_boot_loader
//   Directed bench for imem_boot_loader.  Inputs change 1 ns after the rising
//   edge; level checks run at that point, and a negedge monitor checks every
//   imem_we pulse against the expected-write queue.
// ----------------------------------------------------------------------------
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [6:0]  words_loaded;

  int total = 0;
  int bad   = 0;

  // {addr[7:0], wdata[31:0]} of every write still expected
  logic [39:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  imem_boot_loader #(
    .ADDR_W         (8),
    .DEPTH_WORDS    (64),
    .SYNC_BYTE      (8'hA5)
`ifdef LOADER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte and hold it until it is accepted (bounded wait).
  task automatic send(input logic [7:0] b);
    int w;
    w        = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) check("rx_ready_wait", 40'(rx_ready), 40'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"}, 40'(done), 40'(d));
    check({tag, "_error"}, 40'(error), 40'(e));
    check({tag, "_hold"}, 40'(core_hold), 40'(h));
  endtask

  // ---------------- write scoreboard ----------------
  always @(negedge clk) begin : wr_mon
    logic [39:0] e;
    if (imem_we === 1'b1) begin
      check("wr_expected", 40'(exp_q.size() > 0), 40'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr_data", {imem_addr, imem_wdata}, e);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin : main
    logic [7:0] chk;
    logic [7:0] b;
    logic [31:0] word;

    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);

    // Reset values
    check_status("reset", 1'b0, 1'b0, 1'b1);
    check("reset_rx_ready", 40'(rx_ready), 40'd0);
    check("reset_we", 40'(imem_we), 40'd0);
    check("reset_words", 40'(words_loaded), 40'd0);
    check("reset_addr", 40'(imem_addr), 40'd0);
    check("reset_wdata", 40'(imem_wdata), 40'd0);
    check("reset_state", 40'(dut.state), 40'(IDLE));
    reset = 1'b0;
    idle(2);
    check("idle_rx_ready", 40'(rx_ready), 40'd0);

    // 1: single-word frame
    pulse_start();
    check("t1_rx_ready", 40'(rx_ready), 40'd1);
    exp_q.push_back({8'h00, 32'h12345678});
    send(8'hA5); send(8'h01);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    check("t1_we_latency", 40'(imem_we), 40'd1);
    check("t1_words_at_we", 40'(words_loaded), 40'd1);
    send(8'h08);
    check_status("t1", 1'b1, 1'b0, 1'b0);
    check("t1_rx_ready_done", 40'(rx_ready), 40'd0);
    check("t1_words", 40'(words_loaded), 40'd1);
    check("t1_pending", 40'(exp_q.size()), 40'd0);

    // 2: two words, bad checksum (good one would be 0x08), bytes back-to-back
    pulse_start();
    check_status("t2_armed", 1'b0, 1'b0, 1'b1);
    exp_q.push_back({8'h00, 32'h04030201});
    exp_q.push_back({8'h04, 32'h08070605});
    send(8'hA5); send(8'h02);
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'h00);
    check_status("t2", 1'b0, 1'b1, 1'b1);
    check("t2_words", 40'(words_loaded), 40'd2);
    check("t2_pending", 40'(exp_q.size()), 40'd0);

    // 3: noise before SYNC, empty image
    pulse_start();
    send(8'h00); send(8'hFF);
    check("t3_still_sync", 40'(dut.state), 40'(SYNC));
    send(8'hA5); send(8'h00); send(8'h00);
    check_status("t3", 1'b1, 1'b0, 1'b0);
    check("t3_words", 40'(words_loaded), 40'd0);

    // 4: LEN too large (65), byte held valid afterwards must not be taken
    pulse_start();
    send(8'hA5); send(8'h41);
    check_status("t4", 1'b0, 1'b1, 1'b1);
    check("t4_rx_ready", 40'(rx_ready), 40'd0);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    idle(3);
    rx_valid = 1'b0;
    check("t4_state_err", 40'(dut.state), 40'(ERR));

    // LEN == DEPTH_WORDS boundary: 64 words, last address 0xFC
    pulse_start();
    send(8'hA5); send(8'h40);
    chk = 8'h00;
    for (int w = 0; w < 64; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(w * 4 + k);
        word[k*8 +: 8] = b;
        chk = chk ^ b;
      end
      exp_q.push_back({8'(w * 4), word});
    end
    for (int i = 0; i < 256; i++) send(8'(i));
    send(chk);
    check_status("t64", 1'b1, 1'b0, 1'b0);
    check("t64_words", 40'(words_loaded), 40'd64);
    check("t64_pending", 40'(exp_q.size()), 40'd0);

    // 6: stall inside DATA, then stall in SYNC
    pulse_start();
    send(8'hA5); send(8'h01); send(8'h11);
    idle(20);
`ifdef LOADER_TIMEOUT_EN
    check_status("t6_timeout", 1'b0, 1'b1, 1'b1);
    check("t6_state", 40'(dut.state), 40'(ERR));
`else
    check_status("t6_wait", 1'b0, 1'b0, 1'b1);
    check("t6_rx_ready", 40'(rx_ready), 40'd1);
    exp_q.push_back({8'h00, 32'h44332211});
    send(8'h22); send(8'h33); send(8'h44); send(8'h44);
    check_status("t6_resume", 1'b1, 1'b0, 1'b0);
`endif
    pulse_start();
    idle(20);
    check_status("t6_sync_idle", 1'b0, 1'b0, 1'b1);
    check("t6_sync_state", 40'(dut.state), 40'(SYNC));

    // 5: reset mid-frame after two data bytes, then a full frame
    send(8'hA5); send(8'h01); send(8'hAA); send(8'hBB);
    reset = 1'b1;
    #1;
    check_status("t5_reset", 1'b0, 1'b0, 1'b1);
    check("t5_rx_ready", 40'(rx_ready), 40'd0);
    check("t5_state", 40'(dut.state), 40'(IDLE));
    tick();
    reset = 1'b0;
    idle(1);
    exp_q.push_back({8'h00, 32'h04030201});
    pulse_start();
    send(8'hA5); send(8'h01);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h04);
    check_status("t5_done", 1'b1, 1'b0, 1'b0);
    check("t5_words", 40'(words_loaded), 40'd1);

    idle(3);
    check("final_pending", 40'(exp_q.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
